// File: rtl/mux_eq_pkg.sv
// mux_eq_pkg: shared FSM state type and sweep-vector constants for the mux equivalence checker
package mux_eq_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  localparam int VEC_W = 6;
  localparam int NUM_VEC = 64;
  localparam logic [VEC_W-1:0] LAST_VEC = 6'd63;
endpackage

// File: rtl/mux_eq_vec_gen.sv
// mux_eq_vec_gen: {S,D} sweep counter plus settle timer (clk, rst, clear, advance -> vec, settle_done, last_vec)
module mux_eq_vec_gen
  import mux_eq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [VEC_W-1:0] vec,
  output logic             settle_done,
  output logic             last_vec
);
  localparam logic [3:0] SET_MAX = 4'(SETTLE_CYCLES - 1);
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0] set_q, set_d;
  // The settle timer restarts with every new vector and parks at SET_MAX until the next one.
  always_comb begin
    vec_d = clear ? '0 : advance ? vec_q + 6'd1 : vec_q;
    set_d = (clear || advance) ? '0 : settle_done ? set_q : set_q + 4'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      set_q <= '0;
    end else begin
      vec_q <= vec_d;
      set_q <= set_d;
    end
  end
  assign vec         = vec_q;
  assign settle_done = set_q == SET_MAX;
  assign last_vec    = vec_q == LAST_VEC;
endmodule

// File: rtl/mux_equiv_checker.sv
// mux_equiv_checker: exhaustive {S,D} sweep comparing two 4:1 muxes; ports clk, rst, start, d_out, s_out, ydr_in, yop_in, busy, done, pass, mismatch_count, fail_vec, golden_err; GOLDEN_MODEL_EN adds a D[S] reference check
module mux_equiv_checker
  import mux_eq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [3:0]       d_out,
  output logic [1:0]       s_out,
  input  logic             ydr_in,
  input  logic             yop_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [5:0]       fail_vec,
  output logic             golden_err
);
  state_t state_q;
  logic busy_q, done_q, pass_q, gerr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0] fail_q;
  logic [VEC_W-1:0] vec;
  logic settle_done, last_vec, clear, advance, mm, gm;
  mux_eq_vec_gen #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .advance    (advance),
    .vec        (vec),
    .settle_done(settle_done),
    .last_vec   (last_vec)
  );
`ifdef GOLDEN_MODEL_EN
  assign gm = (ydr_in != d_out[s_out]) || (yop_in != d_out[s_out]);
`else
  assign gm = 1'b0;
`endif
  always_comb begin
    clear   = start && (state_q == IDLE || state_q == DONE);
    advance = state_q == CHECK && !last_vec;
    mm      = (ydr_in != yop_in) || gm;
    cnt_d   = (mm && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      gerr_q  <= 1'b0;
      cnt_q   <= '0;
      fail_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= SETTLE;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
          gerr_q  <= 1'b0;
          cnt_q   <= '0;
          fail_q  <= '0;
        end
        SETTLE: if (settle_done) state_q <= CHECK;
        CHECK: begin
          cnt_q  <= cnt_d;
          gerr_q <= gerr_q || gm;
          if (mm && cnt_q == '0) fail_q <= vec;
          if (last_vec) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= cnt_d == '0;
          end else begin
            state_q <= SETTLE;
          end
        end
      endcase
    end
  end
  assign d_out          = vec[3:0];
  assign s_out          = vec[5:4];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch_count = cnt_q;
  assign fail_vec       = fail_q;
  assign golden_err     = gerr_q;
endmodule

// File: tb/tb_mux_equiv_checker.sv
// tb_mux_equiv_checker: directed scenarios for the mux equivalence checker; edges are numbered with the start-sampling edge as edge 1
module tb_mux_equiv_checker;
  logic clk, rst, start, start3;
  logic [3:0] d_out, d3;
  logic [1:0] s_out, s3;
  logic ydr, yop, busy, done, pass, gerr;
  logic busy3, done3, pass3, gerr3;
  logic [6:0] cnt, cnt3;
  logic [5:0] fail_vec, fail3;
  int mode;
  int checks = 0;
  int failures = 0;
  // Mux models: 0 = both correct, 1 = optimised output stuck at 0, 2 = both return D[3-S].
  assign ydr = (mode == 2) ? d_out[~s_out] : d_out[s_out];
  assign yop = (mode == 1) ? 1'b0 : ydr;
  mux_equiv_checker #(.SETTLE_CYCLES(1), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .d_out(d_out), .s_out(s_out),
    .ydr_in(ydr), .yop_in(yop), .busy(busy), .done(done), .pass(pass),
    .mismatch_count(cnt), .fail_vec(fail_vec), .golden_err(gerr)
  );
  mux_equiv_checker #(.SETTLE_CYCLES(3), .CNT_W(7)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .d_out(d3), .s_out(s3),
    .ydr_in(d3[s3]), .yop_in(d3[s3]), .busy(busy3), .done(done3), .pass(pass3),
    .mismatch_count(cnt3), .fail_vec(fail3), .golden_err(gerr3)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic sweep(output int n);
    start = 1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1; start = 0; start3 = 0; mode = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pass, cnt, fail_vec, d_out, s_out, gerr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, pass, cnt, fail_vec, d_out, s_out, gerr});
    end
    checks++;
    if ({busy3, done3, pass3, cnt3, fail3, d3, s3, gerr3} !== '0) begin
      failures++;
      $display("FAIL reset_outputs3 got=%h want=0", {busy3, done3, pass3, cnt3, fail3, d3, s3, gerr3});
    end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_pass;
    int n;
    mode = 0;
    sweep(n);
    checks++;
    if (n != 129) begin failures++; $display("FAIL pass_latency got=%0d want=129", n); end
    checks++;
    if ({pass, busy} !== 2'b10) begin failures++; $display("FAIL pass_flags got=%b want=10", {pass, busy}); end
    checks++;
    if (cnt !== 7'd0) begin failures++; $display("FAIL pass_count got=%0d want=0", cnt); end
    checks++;
    if (fail_vec !== 6'd0) begin failures++; $display("FAIL pass_failvec got=%b want=000000", fail_vec); end
  endtask
  task automatic test_stuck;
    int n;
    mode = 1;
    sweep(n);
    checks++;
    if (cnt !== 7'd32) begin failures++; $display("FAIL stuck_count got=%0d want=32", cnt); end
    checks++;
    if (fail_vec !== 6'b00_0001) begin failures++; $display("FAIL stuck_failvec got=%b want=000001", fail_vec); end
    checks++;
    if ({done, pass} !== 2'b10) begin failures++; $display("FAIL stuck_flags got=%b want=10", {done, pass}); end
  endtask
  task automatic test_abort;
    int k, n;
    mode = 1;
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    k = 0;
    while ({s_out, d_out} != 6'd20 && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (cnt !== 7'd10) begin failures++; $display("FAIL abort_partial_count got=%0d want=10", cnt); end
    rst = 1;
    #1;
    checks++;
    if ({busy, done, pass, cnt, fail_vec, d_out, s_out, gerr} !== '0) begin
      failures++;
      $display("FAIL abort_reset got=%h want=0", {busy, done, pass, cnt, fail_vec, d_out, s_out, gerr});
    end
    @(negedge clk);
    rst = 0;
    mode = 0;
    @(negedge clk);
    sweep(n);
    checks++;
    if ({n == 129, pass, cnt, fail_vec} !== {1'b1, 1'b1, 7'd0, 6'd0}) begin
      failures++;
      $display("FAIL abort_rerun got=n%0d/p%b/c%0d/f%b want=n129/p1/c0/f000000", n, pass, cnt, fail_vec);
    end
  endtask
  task automatic test_back_to_back;
    int n, first, second;
    logic low_after;
    mode = 0;
    start = 1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == 10);
    end
    start = 0;
    checks++;
    if (n != 129) begin failures++; $display("FAIL busy_start_latency got=%0d want=129", n); end
    start = 1;
    @(posedge clk);
    n = 1; first = 0; second = 0; low_after = 1'b1;
    while (n < 300) begin
      @(negedge clk);
      if (done && first == 0) first = n;
      else if (done && n > first + 1 && second == 0) second = n;
      if (first != 0 && n == first + 1) low_after = done;
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    start = 0;
    checks++;
    if (first != 129) begin failures++; $display("FAIL held_first_done got=%0d want=129", first); end
    checks++;
    if (second != 258) begin failures++; $display("FAIL held_second_done got=%0d want=258", second); end
    checks++;
    if (low_after !== 1'b0) begin failures++; $display("FAIL held_done_pulse got=%b want=0", low_after); end
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({done, pass} !== 2'b11) begin failures++; $display("FAIL held_final got=%b want=11", {done, pass}); end
  endtask
  task automatic test_golden;
    int n;
    mode = 2;
    sweep(n);
`ifdef GOLDEN_MODEL_EN
    checks++;
    if ({cnt, gerr, pass} !== {7'd32, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL golden_on got=c%0d/g%b/p%b want=c32/g1/p0", cnt, gerr, pass);
    end
`else
    checks++;
    if ({cnt, gerr, pass} !== {7'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL golden_off got=c%0d/g%b/p%b want=c0/g0/p1", cnt, gerr, pass);
    end
`endif
    mode = 0;
  endtask
  task automatic test_settle3;
    int n, last;
    logic [5:0] prev;
    start3 = 1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start3 = 0;
    prev = {s3, d3};
    last = 1;
    while (!done3 && n < 1000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if ({s3, d3} != prev) begin
        checks++;
        if (n - last != 4 || {s3, d3} != prev + 6'd1) begin
          failures++;
          $display("FAIL settle3_step got=vec%0d_after%0d want=vec%0d_after4", {s3, d3}, n - last, prev + 6'd1);
        end
        last = n;
        prev = {s3, d3};
      end
    end
    checks++;
    if (n != 257) begin failures++; $display("FAIL settle3_latency got=%0d want=257", n); end
    checks++;
    if ({pass3, cnt3} !== {1'b1, 7'd0}) begin failures++; $display("FAIL settle3_result got=p%b/c%0d want=p1/c0", pass3, cnt3); end
  endtask
  initial begin
    test_reset;
    test_pass;
    test_stuck;
    test_abort;
    test_back_to_back;
    test_golden;
    test_settle3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
